// File: rtl/fir_polyphase_iq.sv
// Two-channel (I/Q) polyphase pulse-shaping interpolator: +/-1 symbol mapping,
// OVER_SAMP-phase interpolation, runtime-loadable N_BAUDS-tap-per-phase filter.
module fir_polyphase_iq #(
  parameter int NB_COEFF  = 10,
  parameter int NBF_COEFF = 8,
  parameter int OVER_SAMP = 8,
  parameter int N_BAUDS   = 7,
  parameter int NB_COUNT  = 3,
  parameter int NB_ADDR   = 6,
  parameter int NB_OUTPUT = 13
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  input  logic                 i_valid,
  input  logic                 i_sym_i,
  input  logic                 i_sym_q,
  output logic                 o_sym_req,
  output logic                 o_underrun,
  input  logic                 i_coeff_we,
  input  logic [NB_ADDR-1:0]   i_coeff_addr,
  input  logic [NB_COEFF-1:0]  i_coeff_data,
  output logic [NB_OUTPUT-1:0] o_data_i,
  output logic [NB_OUTPUT-1:0] o_data_q,
  output logic [NB_COUNT-1:0]  o_phase,
  output logic                 o_valid
);

  localparam int unsigned N_COEFF = OVER_SAMP * N_BAUDS;

  if (NBF_COEFF > NB_COEFF || (1 << NB_COUNT) != OVER_SAMP) begin : g_bad_params
    $error("fir_polyphase_iq: inconsistent coefficient or phase-counter parameters");
  end

  logic [NB_COUNT-1:0]        cnt;
  logic [N_BAUDS-1:0]         tap_act;
  logic [N_BAUDS-1:0]         tap_i;
  logic [N_BAUDS-1:0]         tap_q;
  logic signed [NB_COEFF-1:0] coeff [N_COEFF];
  logic signed [NB_OUTPUT-1:0] acc_i;
  logic signed [NB_OUTPUT-1:0] acc_q;
  logic [NB_ADDR-1:0]         idx;
  logic                       accept;

  // Negate one bit wider so the most negative coefficient flips exactly.
  function automatic logic signed [NB_OUTPUT-1:0] tap_term(
    input logic act,
    input logic neg,
    input logic signed [NB_COEFF-1:0] c
  );
    logic signed [NB_COEFF:0] ext;
    ext = {c[NB_COEFF-1], c};
    if (neg)
      ext = -ext;
    return act ? NB_OUTPUT'(ext) : '0;
  endfunction

  assign o_sym_req = (cnt == NB_COUNT'(OVER_SAMP - 1));
  assign accept    = i_enable && o_sym_req;

  always_comb begin
    acc_i = '0;
    acc_q = '0;
    idx   = '0;
    for (int unsigned k = 0; k < N_BAUDS; k++) begin
      idx   = NB_ADDR'(k * OVER_SAMP) + NB_ADDR'(cnt);
      acc_i = acc_i + tap_term(tap_act[k], tap_i[k], coeff[idx]);
      acc_q = acc_q + tap_term(tap_act[k], tap_q[k], coeff[idx]);
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      cnt     <= '0;
      tap_act <= '0;
      tap_i   <= '0;
      tap_q   <= '0;
    end else if (i_enable) begin
      cnt <= cnt + 1'b1;
      if (accept) begin
        tap_act <= {tap_act[N_BAUDS-2:0], i_valid};
        tap_i   <= {tap_i[N_BAUDS-2:0], i_sym_i};
        tap_q   <= {tap_q[N_BAUDS-2:0], i_sym_q};
      end
    end
  end

  // Coefficient storage ignores i_enable; reads in the same cycle see the old value.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      coeff <= '{default: '0};
    end else if (i_coeff_we && (32'(i_coeff_addr) < N_COEFF)) begin
      coeff[i_coeff_addr] <= i_coeff_data;
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      o_data_i   <= '0;
      o_data_q   <= '0;
      o_phase    <= '0;
      o_valid    <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      o_underrun <= accept && !i_valid;
      o_valid    <= i_enable;
      if (i_enable) begin
        o_data_i <= acc_i;
        o_data_q <= acc_q;
        o_phase  <= cnt;
      end
    end
  end

endmodule

// File: tb/tb_fir_polyphase_iq.sv
// Randomized bench for fir_polyphase_iq against a symbol-history reference model.
module tb_fir_polyphase_iq;
  localparam int NB_COEFF  = 10;
  localparam int OVER_SAMP = 8;
  localparam int N_BAUDS   = 7;
  localparam int NB_COUNT  = 3;
  localparam int NB_ADDR   = 6;
  localparam int NB_OUTPUT = 13;
  localparam int N_COEFF   = OVER_SAMP * N_BAUDS;

  logic clk = 1'b0;
  logic i_rst, i_enable, i_valid, i_sym_i, i_sym_q, i_coeff_we;
  logic [NB_ADDR-1:0]   i_coeff_addr;
  logic [NB_COEFF-1:0]  i_coeff_data;
  logic o_sym_req, o_underrun, o_valid;
  logic [NB_OUTPUT-1:0] o_data_i, o_data_q;
  logic [NB_COUNT-1:0]  o_phase;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: coefficients, symbol values (+1/-1/0) newest first, phase.
  int mc [N_COEFF];
  int hist_i [$];
  int hist_q [$];
  int m_cnt;
  int e_i, e_q, e_ph, e_val, e_und;

  always #5 clk = ~clk;

  fir_polyphase_iq #(
    .NB_COEFF (NB_COEFF),
    .NBF_COEFF(8),
    .OVER_SAMP(OVER_SAMP),
    .N_BAUDS  (N_BAUDS),
    .NB_COUNT (NB_COUNT),
    .NB_ADDR  (NB_ADDR),
    .NB_OUTPUT(NB_OUTPUT)
  ) dut (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_enable    (i_enable),
    .i_valid     (i_valid),
    .i_sym_i     (i_sym_i),
    .i_sym_q     (i_sym_q),
    .o_sym_req   (o_sym_req),
    .o_underrun  (o_underrun),
    .i_coeff_we  (i_coeff_we),
    .i_coeff_addr(i_coeff_addr),
    .i_coeff_data(i_coeff_data),
    .o_data_i    (o_data_i),
    .o_data_q    (o_data_q),
    .o_phase     (o_phase),
    .o_valid     (o_valid)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < N_COEFF; a++) mc[a] = 0;
    hist_i.delete();
    hist_q.delete();
    for (int k = 0; k < N_BAUDS; k++) begin
      hist_i.push_back(0);
      hist_q.push_back(0);
    end
    m_cnt = 0;
    e_i = 0; e_q = 0; e_ph = 0; e_val = 0; e_und = 0;
  endtask

  // Effect of one rising edge on the reference, given the inputs presented.
  task automatic model_edge();
    bit req;
    req   = (m_cnt == OVER_SAMP - 1);
    e_und = int'(i_enable && req && !i_valid);
    if (i_enable) begin
      e_i = 0;
      e_q = 0;
      for (int k = 0; k < N_BAUDS; k++) begin
        e_i += hist_i[k] * mc[k * OVER_SAMP + m_cnt];
        e_q += hist_q[k] * mc[k * OVER_SAMP + m_cnt];
      end
      e_ph  = m_cnt;
      e_val = 1;
      if (req) begin
        hist_i.push_front(!i_valid ? 0 : (i_sym_i ? -1 : 1));
        hist_q.push_front(!i_valid ? 0 : (i_sym_q ? -1 : 1));
        void'(hist_i.pop_back());
        void'(hist_q.pop_back());
      end
      m_cnt = (m_cnt + 1) % OVER_SAMP;
    end else begin
      e_val = 0;
    end
    if (i_coeff_we && i_coeff_addr < N_COEFF)
      mc[i_coeff_addr] = int'($signed(i_coeff_data));
  endtask

  task automatic cycle(input logic en, input logic v, input logic si, input logic sq,
                       input logic we, input int addr, input int data);
    i_enable     = en;
    i_valid      = v;
    i_sym_i      = si;
    i_sym_q      = sq;
    i_coeff_we   = we;
    i_coeff_addr = addr[NB_ADDR-1:0];
    i_coeff_data = data[NB_COEFF-1:0];
    check("sym_req", int'(o_sym_req), int'(m_cnt == OVER_SAMP - 1));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("valid", int'(o_valid), e_val);
    check("underrun", int'(o_underrun), e_und);
    if (e_val != 0) check("phase", int'(o_phase), e_ph);
    check("data_i", int'($signed(o_data_i)), e_i);
    check("data_q", int'($signed(o_data_q)), e_q);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_i"}, int'($signed(o_data_i)), 0);
    check({tag, "_data_q"}, int'($signed(o_data_q)), 0);
    check({tag, "_phase"}, int'(o_phase), 0);
    check({tag, "_valid"}, int'(o_valid), 0);
    check({tag, "_underrun"}, int'(o_underrun), 0);
    check({tag, "_sym_req"}, int'(o_sym_req), 0);
  endtask

  // One symbol pair presented at the first request, then starved.
  task automatic single_symbol(input logic si, input logic sq, input int n);
    bit sent;
    sent = 0;
    for (int c = 0; c < n; c++) begin
      bit req;
      req = (m_cnt == OVER_SAMP - 1);
      cycle(1'b1, req && !sent, si, sq, 1'b0, 0, 0);
      if (req) sent = 1;
    end
  endtask

  initial begin
    i_rst = 1'b1; i_enable = 1'b0; i_valid = 1'b0; i_sym_i = 1'b0; i_sym_q = 1'b0;
    i_coeff_we = 1'b0; i_coeff_addr = '0; i_coeff_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    i_rst = 1'b0;

    // Tap-0 ramp coefficients, single +1 symbol then underruns.
    for (int p = 0; p < OVER_SAMP; p++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, p, p + 1);
    single_symbol(1'b0, 1'b0, 40);
    // Opposite signs on I and Q.
    single_symbol(1'b1, 1'b0, 40);

    // Full-scale negative coefficients with a continuous -1 stream.
    for (int a = 0; a < N_COEFF; a++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, a, -512);
    for (int c = 0; c < 80; c++) cycle(1'b1, 1'b1, 1'b1, 1'($urandom), 1'b0, 0, 0);
    check("full_scale_i", int'($signed(o_data_i)), 3584);

    // Random coefficients, then enable held low for 3 cycles mid-symbol.
    for (int a = 0; a < N_COEFF; a++)
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, a, int'($urandom_range(0, 1023)));
    for (int c = 0; c < 3; c++) cycle(1'b1, 1'b1, 1'($urandom), 1'($urandom), 1'b0, 0, 0);
    for (int c = 0; c < 3; c++) cycle(1'b0, 1'b1, 1'($urandom), 1'($urandom), 1'b0, 0, 0);
    for (int c = 0; c < 20; c++) cycle(1'b1, 1'b1, 1'($urandom), 1'($urandom), 1'b0, 0, 0);

    // Out-of-range writes, and a live write to tap 1 phase 3.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 56, 511);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 63, -300);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1 * OVER_SAMP + 3, -512);
    for (int c = 0; c < 24; c++) cycle(1'b1, 1'b1, 1'($urandom), 1'($urandom), 1'b0, 0, 0);

    for (int c = 0; c < 600; c++)
      cycle(1'(($urandom % 8) != 0), 1'(($urandom % 4) != 0), 1'($urandom), 1'($urandom),
            1'(($urandom % 6) == 0), int'($urandom % 64), int'($urandom));

    // Asynchronous reset mid-symbol.
    while (m_cnt != 3) cycle(1'b1, 1'b1, 1'($urandom), 1'($urandom), 1'b0, 0, 0);
    #2 i_rst = 1'b1;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    i_rst = 1'b0;
    model_reset();
    for (int c = 0; c < 12; c++) cycle(1'b1, 1'b1, 1'($urandom), 1'($urandom), 1'b0, 0, 0);
    for (int a = 0; a < N_COEFF; a++)
      cycle(1'b1, 1'b1, 1'($urandom), 1'($urandom), 1'b1, a, int'($urandom_range(0, 1023)));
    for (int c = 0; c < 100; c++)
      cycle(1'(($urandom % 5) != 0), 1'(($urandom % 3) != 0), 1'($urandom), 1'($urandom),
            1'b0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
